// File: rtl/bsg_link_credit_return_fifo_if.sv
// Core-side handshake bundle for the link credit-return FIFO.
// The master side is the link/core environment; the slave side is the FIFO.
interface bsg_link_credit_return_fifo_if #(
    parameter int width_p = 64,
    parameter int els_p   = 8
);
    localparam int cnt_w_lp = $clog2(els_p) + 1;

    logic [width_p-1:0]  data_i;
    logic                valid_i;
    logic [width_p-1:0]  data_o;
    logic                valid_o;
    logic                yumi_i;
    logic                core_token_r_o;
    logic                overflow_r_o;
    logic [cnt_w_lp-1:0] count_o;

    modport master (
        output data_i,
        output valid_i,
        output yumi_i,
        input  data_o,
        input  valid_o,
        input  core_token_r_o,
        input  overflow_r_o,
        input  count_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        input  yumi_i,
        output data_o,
        output valid_o,
        output core_token_r_o,
        output overflow_r_o,
        output count_o
    );
endinterface

// File: rtl/bsg_link_credit_return_fifo.sv
// Link downstream receive FIFO with decimated credit-token return.
// BSG_LINK_CREDIT_PULSE_EN: token is a one-cycle pulse instead of a toggle.
module bsg_link_credit_return_fifo #(
    parameter int width_p                = 64,
    parameter int els_p                  = 8,
    parameter int lg_credit_decimation_p = 2
) (
    input logic core_clk_i,
    input logic core_link_reset_n_i,
    bsg_link_credit_return_fifo_if.slave link
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int ptr_w_lp  = lg_els_lp + 1;
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic                token_r;
    logic                overflow_r;

    logic empty;
    logic full;
    logic deq;
    logic enq;
    logic drop;
    logic credit_wrap;
    logic token_n;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[lg_els_lp-1:0] == rd_ptr_r[lg_els_lp-1:0])
                 & (wr_ptr_r[lg_els_lp] != rd_ptr_r[lg_els_lp]);

    // A full FIFO accepts a word only when the head leaves in the same cycle.
    assign deq  = link.yumi_i & ~empty;
    assign enq  = link.valid_i & (~full | deq);
    assign drop = link.valid_i & full & ~deq;

    always_ff @(posedge core_clk_i) begin
        if (enq) begin
            mem[wr_ptr_r[lg_els_lp-1:0]] <= link.data_i;
        end
    end

    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (enq) wr_ptr_r <= wr_ptr_r + ptr_one_lp;
            if (deq) rd_ptr_r <= rd_ptr_r + ptr_one_lp;
            if (drop) overflow_r <= 1'b1;
        end
    end

    generate
        if (lg_credit_decimation_p == 0) begin : g_no_dec
            assign credit_wrap = deq;
        end else begin : g_dec
            localparam int cw_lp = lg_credit_decimation_p;
            localparam logic [cw_lp-1:0] credit_one_lp = cw_lp'(1);
            logic [cw_lp-1:0] credit_r;

            always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
                if (!core_link_reset_n_i) begin
                    credit_r <= '0;
                end else if (deq) begin
                    credit_r <= credit_r + credit_one_lp;
                end
            end

            assign credit_wrap = deq & (&credit_r);
        end
    endgenerate

    always_comb begin
        token_n = token_r;
`ifdef BSG_LINK_CREDIT_PULSE_EN
        token_n = credit_wrap;
`else
        token_n = token_r ^ credit_wrap;
`endif
    end

    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            token_r <= 1'b0;
        end else begin
            token_r <= token_n;
        end
    end

    assign link.data_o         = mem[rd_ptr_r[lg_els_lp-1:0]];
    assign link.valid_o        = ~empty;
    assign link.count_o        = wr_ptr_r - rd_ptr_r;
    assign link.core_token_r_o = token_r;
    assign link.overflow_r_o   = overflow_r;
endmodule
